sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Clocked write driver for the SR latch storage cell: it accepts one-bit write commands over a valid/ready handshake and converts each into a clean, fixed-width set or reset pulse on the latch inputs. It then waits a settle interval, reads the latch outputs back, and reports completion and a verify result. It sits between synchronous control logic and any SR latch instance, and guarantees the latch never sees set and reset active together.

## Interface
- PULSE_CYCLES, 2: width of the set/reset pulse in clk cycles; legal range 1..255.
- SETTLE_CYCLES, 2: cycles with both latch inputs inactive before readback; legal range 1..255.
- ACTIVE_LOW, 0: 0 = latch inputs active-high (idle 0); 1 = active-low (idle 1, NAND latch).

- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- cmd_valid  in  1  write command present.
- cmd_value  in  1  1 = set latch (q→1), 0 = reset latch (q→0).
- cmd_ready  out  1  driver can accept a command this cycle.
- set  out  1  to latch set input, polarity per ACTIVE_LOW.
- reset  out  1  to latch reset input, polarity per ACTIVE_LOW.
- q  in  1  latch true output.
- q_n  in  1  latch complementary output.
- done  out  1  one-cycle pulse: command finished.
- error  out  1  valid only with done; readback mismatch.
- err_count  out  8  saturating count of errored commands.

## Operation
- All outputs are registered. States: IDLE, PULSE, SETTLE, CHECK.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready: latch cmd_value into an internal register, load the counter with PULSE_CYCLES-1, go to PULSE. cmd_value is ignored when no handshake occurs.
- PULSE: the selected output is active, the other inactive. The counter decrements each cycle. At 0: load SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: both outputs inactive. The counter decrements. At 0: sample q and q_n, compute mismatch = (q != stored value) | (q == q_n), go to CHECK.
- CHECK: done=1 and error=mismatch for exactly this cycle. If mismatch, err_count increments, saturating at 255. Next state is IDLE.
- cmd_ready=0 in PULSE, SETTLE and CHECK. Commands are never queued.
- set and reset are never active in the same cycle, in any state or across any reset. The idle level is 0 when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1.
- Counter is 8 bits. Parameter values outside 1..255 are unsupported.

## Timing
- Handshake accepted at rising edge E0 (cycle T). The pulse is active on cycles T+1 … T+PULSE_CYCLES.
- Settle occupies cycles T+PULSE_CYCLES+1 … T+PULSE_CYCLES+SETTLE_CYCLES.
- q and q_n are sampled at the edge ending the last SETTLE cycle.
- done and error are high in cycle T+PULSE_CYCLES+SETTLE_CYCLES+1.
- cmd_ready returns high in the next cycle. Command-to-command throughput is PULSE_CYCLES+SETTLE_CYCLES+2 cycles.
- Reset (reset_n=0 at a rising edge), taking effect at that edge from any state: state=IDLE, set/reset at the inactive level, done=0, error=0, err_count=0, cmd_ready=0.
- cmd_ready goes to 1 at the first edge with reset_n=1. A pulse in progress is truncated and produces no done.
- cmd_valid asserted during reset is not accepted.
- Back-to-back commands with cmd_valid held high: the second is accepted on the first IDLE cycle, so both latch inputs stay inactive for at least SETTLE_CYCLES+1 cycles between pulses.

## Test plan
Conditions for all scenarios: PULSE_CYCLES=2, SETTLE_CYCLES=2, ACTIVE_LOW=0, with a behavioural SR latch model in the loop unless stated otherwise.
- Reset then write 1 at cycle 10: set high on cycles 11–12, reset stays 0; done=1, error=0 on cycle 15; q=1; cmd_ready high again on cycle 16.
- Write 0 after a write 1: reset pulse for 2 cycles; done with error=0; q=0, q_n=1; err_count=0.
- Latch model disconnected, q forced 0 and q_n forced 0, then write 1: done with error=1; err_count=1. Repeat 300 times: err_count saturates at 255.
- reset_n pulled low on the second PULSE cycle: set goes 0 at that edge; no done; err_count=0; cmd_ready=1 on the first cycle after reset_n rises.
- cmd_valid held high with alternating values for 4 commands: accepts at cycles spaced exactly 6 apart; the monitor never sees set&reset=1.
- ACTIVE_LOW=1: outputs idle at 1; write 1 drives set low for 2 cycles while reset stays 1.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//
// Write driver for an SR latch storage cell. A one-bit write command is taken
// over a valid/ready handshake and turned into a fixed-width pulse on either
// the latch set input or its reset input, never both. After the pulse, both
// inputs rest for a settle interval. The latch outputs are then read back and
// the driver reports completion together with a verify result.
//
// Parameters
//   PULSE_CYCLES   width of the set/reset pulse in clk cycles (1..255)
//   SETTLE_CYCLES  inactive cycles before readback (1..255)
//   ACTIVE_LOW     0: latch inputs active-high; 1: active-low (NAND latch)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset_n    in   synchronous active-low reset
//   cmd_valid  in   write command present
//   cmd_value  in   1 = set latch, 0 = reset latch
//   cmd_ready  out  command can be accepted this cycle
//   set        out  latch set input (polarity per ACTIVE_LOW)
//   reset      out  latch reset input (polarity per ACTIVE_LOW)
//   q, q_n     in   latch outputs, read back after settle
//   done       out  one-cycle completion pulse
//   error      out  readback mismatch, qualified by done
//   err_count  out  saturating count of errored commands
//
// State table
//   IDLE   | waiting for a command, cmd_ready high
//   PULSE  | selected latch input active, counting down the pulse width
//   SETTLE | both latch inputs inactive, counting down the settle time
//   CHECK  | done/error presented for exactly one cycle
`timescale 1ns/1ps

module sr_latch_driver #(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic       cmd_value,
    output logic       cmd_ready,
    output logic       set,
    output logic       reset,
    input  logic       q,
    input  logic       q_n,
    output logic       done,
    output logic       error,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic       IDLE_LVL    = ACTIVE_LOW;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_value;
    logic       w_value_next;

    logic       r_cmd_ready;
    logic       r_set;
    logic       r_reset;
    logic       r_done;
    logic       r_error;
    logic [7:0] r_err_count;

    logic       w_cmd_ready_next;
    logic       w_set_next;
    logic       w_reset_next;
    logic       w_done_next;
    logic       w_error_next;
    logic [7:0] w_err_count_next;

    logic       w_accept;
    logic       w_mismatch;

    // The registered ready is used, so the cycle right after reset release
    // (ready still low) can never accept a command.
    assign w_accept   = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;

    // A healthy latch must hold the written value with complementary outputs.
    assign w_mismatch = (q != r_value) || (q == q_n);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_value <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_value <= w_value_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_value_next = r_value;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_value_next = cmd_value;
                    w_cnt_next   = PULSE_LOAD;
                    w_state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_next   = SETTLE_LOAD;
                    w_state_next = ST_SETTLE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = ST_CHECK;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: computed from the upcoming state so every output is a
    // register that changes on the same edge as the state itself.
    always_comb begin
        w_set_next       = IDLE_LVL;
        w_reset_next     = IDLE_LVL;
        w_cmd_ready_next = (w_state_next == ST_IDLE);
        w_done_next      = (w_state_next == ST_CHECK);
        w_error_next     = 1'b0;
        w_err_count_next = r_err_count;

        // Only one of the two inputs is ever driven active, selected by the
        // stored value, so set and reset cannot overlap.
        if (w_state_next == ST_PULSE) begin
            if (w_value_next) begin
                w_set_next = ~IDLE_LVL;
            end else begin
                w_reset_next = ~IDLE_LVL;
            end
        end

        // CHECK is only entered from the last SETTLE cycle, which is exactly
        // the edge at which q/q_n are sampled.
        if (w_done_next) begin
            w_error_next = w_mismatch;
            if (w_mismatch && (r_err_count != 8'hFF)) begin
                w_err_count_next = r_err_count + 8'd1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cmd_ready <= 1'b0;
            r_set       <= IDLE_LVL;
            r_reset     <= IDLE_LVL;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_cmd_ready <= w_cmd_ready_next;
            r_set       <= w_set_next;
            r_reset     <= w_reset_next;
            r_done      <= w_done_next;
            r_error     <= w_error_next;
            r_err_count <= w_err_count_next;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign set       = r_set;
    assign reset     = r_reset;
    assign done      = r_done;
    assign error     = r_error;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Testbench for sr_latch_driver: behavioural SR latch in the loop, with the
// option to disconnect it and force q/q_n. A second instance checks the
// active-low input polarity.
`timescale 1ns/1ps

module tb_sr_latch_driver;

    localparam int P = 2;
    localparam int S = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_value;
    logic       cmd_ready;
    logic       set_o;
    logic       reset_o;
    logic       q;
    logic       q_n;
    logic       done;
    logic       error;
    logic [7:0] err_count;

    logic       al_valid;
    logic       al_value;
    logic       al_ready;
    logic       al_set;
    logic       al_reset;
    logic       al_q;
    logic       al_q_n;
    logic       al_done;
    logic       al_error;
    logic [7:0] al_err_count;

    sr_latch_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_value (cmd_value),
        .cmd_ready (cmd_ready),
        .set       (set_o),
        .reset     (reset_o),
        .q         (q),
        .q_n       (q_n),
        .done      (done),
        .error     (error),
        .err_count (err_count)
    );

    sr_latch_driver #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut_al (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (al_valid),
        .cmd_value (al_value),
        .cmd_ready (al_ready),
        .set       (al_set),
        .reset     (al_reset),
        .q         (al_q),
        .q_n       (al_q_n),
        .done      (al_done),
        .error     (al_error),
        .err_count (al_err_count)
    );

    // Behavioural SR latches
    logic lat_q    = 1'b0;
    logic lat_al_q = 1'b0;
    logic force_en = 1'b0;
    logic f_q      = 1'b0;
    logic f_qn     = 1'b0;

    always @(set_o or reset_o) begin
        if (set_o === 1'b1)        lat_q = 1'b1;
        else if (reset_o === 1'b1) lat_q = 1'b0;
    end

    always @(al_set or al_reset) begin
        if (al_set === 1'b0)        lat_al_q = 1'b1;
        else if (al_reset === 1'b0) lat_al_q = 1'b0;
    end

    assign q      = force_en ? f_q  : lat_q;
    assign q_n    = force_en ? f_qn : ~lat_q;
    assign al_q   = lat_al_q;
    assign al_q_n = ~lat_al_q;

    int n_checks = 0;
    int n_errors = 0;
    int model_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit overlap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (set_o === 1'b1 && reset_o === 1'b1) overlap = 1'b1;
            if (al_set === 1'b0 && al_reset === 1'b0) overlap = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One full write on the active-high instance, checked cycle by cycle
    // against the timeline: pulse for P cycles, settle for S, done next.
    task automatic do_cmd(input logic v, input logic exp_err);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_value = v;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", 32'(waited < 20), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_value = 1'($urandom);
        for (int k = 0; k < P; k++) begin
            chk("pulse_set", 32'(set_o), 32'(v));
            chk("pulse_rst", 32'(reset_o), 32'(!v));
            chk("pulse_rdy", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        for (int k = 0; k < S; k++) begin
            chk("settle_set", 32'(set_o), 0);
            chk("settle_rst", 32'(reset_o), 0);
            chk("settle_done", 32'(done), 0);
            @(negedge clk);
        end
        chk("done", 32'(done), 1);
        chk("error", 32'(error), 32'(exp_err));
        chk("check_rdy", 32'(cmd_ready), 0);
        if (exp_err && model_err < 255) model_err++;
        @(negedge clk);
        chk("done_len", 32'(done), 0);
        chk("ready_back", 32'(cmd_ready), 1);
        chk("err_count", 32'(err_count), 32'(model_err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        logic fe;
        logic e;
        bit   seen_done;
        int   acc [4];
        int   n_acc;
        int   t;

        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_value = 1'b1;
        al_valid  = 1'b0;
        al_value  = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Reset state; cmd_valid held during reset must not be accepted.
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_set", 32'(set_o), 0);
        chk("rst_reset", 32'(reset_o), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        chk("rst_al_set", 32'(al_set), 1);
        chk("rst_al_reset", 32'(al_reset), 1);
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(cmd_ready), 1);
        chk("rel_set", 32'(set_o), 0);

        // Write 1, then write 0, latch connected.
        do_cmd(1'b1, 1'b0);
        chk("q_after_set", 32'(q), 1);
        do_cmd(1'b0, 1'b0);
        chk("q_after_rst", 32'(q), 0);
        chk("qn_after_rst", 32'(q_n), 1);
        chk("errcnt_clean", 32'(err_count), 0);

        // Active-low instance: write 1.
        chk("al_idle_set", 32'(al_set), 1);
        chk("al_idle_reset", 32'(al_reset), 1);
        chk("al_ready", 32'(al_ready), 1);
        al_valid = 1'b1;
        al_value = 1'b1;
        @(negedge clk);
        al_valid = 1'b0;
        for (int k = 0; k < P; k++) begin
            chk("al_pulse_set", 32'(al_set), 0);
            chk("al_pulse_reset", 32'(al_reset), 1);
            @(negedge clk);
        end
        for (int k = 0; k < S; k++) begin
            chk("al_settle_set", 32'(al_set), 1);
            chk("al_settle_reset", 32'(al_reset), 1);
            @(negedge clk);
        end
        chk("al_done", 32'(al_done), 1);
        chk("al_error", 32'(al_error), 0);
        chk("al_q", 32'(al_q), 1);
        @(negedge clk);

        // Randomized writes, sometimes with the latch disconnected.
        for (int i = 0; i < 40; i++) begin
            v  = 1'($urandom_range(0, 1));
            fe = ($urandom_range(0, 3) == 0);
            f_q  = 1'($urandom_range(0, 1));
            f_qn = 1'($urandom_range(0, 1));
            force_en = fe;
            e = fe ? ((f_q != v) || (f_q == f_qn)) : 1'b0;
            do_cmd(v, e);
            force_en = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                cmd_value = 1'($urandom);
                @(negedge clk);
            end
        end

        // Stuck latch outputs: every write errors, count saturates.
        force_en = 1'b1;
        f_q  = 1'b0;
        f_qn = 1'b0;
        repeat (300) do_cmd(1'b1, 1'b1);
        chk("errcnt_sat", 32'(err_count), 255);
        force_en = 1'b0;

        // Reset during the second PULSE cycle.
        cmd_valid = 1'b1;
        cmd_value = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_pulse1", 32'(set_o), 1);
        @(negedge clk);
        chk("mid_pulse2", 32'(set_o), 1);
        reset_n = 1'b0;
        @(negedge clk);
        model_err = 0;
        chk("mid_rst_set", 32'(set_o), 0);
        chk("mid_rst_reset", 32'(reset_o), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        chk("mid_rst_errcnt", 32'(err_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(cmd_ready), 1);
        seen_done = 1'b0;
        repeat (8) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_no_done", 32'(seen_done), 0);

        // Back-to-back with cmd_valid held high, alternating values.
        n_acc = 0;
        t = 0;
        cmd_valid = 1'b1;
        while (n_acc < 4 && t < 80) begin
            cmd_value = (n_acc % 2 == 0);
            if (cmd_ready === 1'b1) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        chk("b2b_count", 32'(n_acc), 4);
        for (int i = 1; i < 4; i++) begin
            if (i < n_acc) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(P + S + 2));
        end
        repeat (10) @(negedge clk);
        chk("b2b_errcnt", 32'(err_count), 0);
        chk("b2b_q_last", 32'(q), 0);

        chk("no_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
